// File: rtl/reg_file_pkg.sv
// Shared sizing constants and types for the decode-stage register file.
package reg_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One read port: selects a register and captures it on the falling clock edge.
// Output is cleared asynchronously by reset and holds between falling edges.
module reg_file_read_port #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = reg_file_pkg::NUM_REGS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  i_regs,
  input  logic [ADDR_WIDTH-1:0]                i_addr,
  output logic [DATA_WIDTH-1:0]                o_rd
);

  logic [DATA_WIDTH-1:0] w_sel;
  logic [DATA_WIDTH-1:0] r_rd;

  assign w_sel = i_regs[i_addr];

  // Falling-edge capture lets a write committed on the rising edge be seen in the same cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_sel;
    end
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two falling-edge-registered read ports, one rising-edge write port.
// Reset loads reg[i] = i; reg[0] is never written afterwards.
module reg_file #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = reg_file_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] PR1,
  input  logic [ADDR_WIDTH-1:0] PR2,
  input  logic [ADDR_WIDTH-1:0] WR,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  import reg_file_pkg::*;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
  logic                                w_wr_en;

  assign w_wr_en = write && (WR != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_WIDTH'(i);
      end
    end else if (w_wr_en) begin
      r_regs[WR] <= WD;
    end
  end

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rd1 (
    .clk    (clk),
    .rst_n  (reset),
    .i_regs (r_regs),
    .i_addr (PR1),
    .o_rd   (RD1)
  );

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rd2 (
    .clk    (clk),
    .rst_n  (reset),
    .i_regs (r_regs),
    .i_addr (PR2),
    .o_rd   (RD2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read data, a monitor compares.
`timescale 1ns/1ps
module tb_reg_file;
  import reg_file_pkg::*;

  typedef struct {
    reg_data_t rd1;
    reg_data_t rd2;
    string     name;
  } exp_t;

  logic      clk;
  logic      reset;
  logic      write;
  reg_addr_t PR1, PR2, WR;
  reg_data_t WD;
  reg_data_t RD1, RD2;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event async_chk;

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .write (write),
    .PR1   (PR1),
    .PR2   (PR2),
    .WR    (WR),
    .WD    (WD),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after every falling edge (or an async-check request) drain and compare the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or async_chk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (RD1 !== e.rd1 || RD2 !== e.rd2) begin
          n_fail++;
          $display("FAIL %s: RD1=%h RD2=%h expected RD1=%h RD2=%h", e.name, RD1, RD2, e.rd1, e.rd2);
        end
      end
    end
  end

  task automatic push(input reg_data_t rd1, input reg_data_t rd2, input string name);
    exp_t e;
    e.rd1 = rd1; e.rd2 = rd2; e.name = name;
    q.push_back(e);
  endtask

  // One cycle: drive after a falling edge; the rising edge writes, the next falling edge reads.
  task automatic step(input logic rst, input logic we, input reg_addr_t wr, input reg_data_t wd,
                      input reg_addr_t pr1, input reg_addr_t pr2,
                      input reg_data_t e1, input reg_data_t e2, input string name);
    @(negedge clk);
    #2;
    reset = rst; write = we; WR = wr; WD = wd; PR1 = pr1; PR2 = pr2;
    push(e1, e2, name);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    push('0, '0, name);
    -> async_chk;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; write = 1'b1; WR = 5'd4; WD = 32'd99; PR1 = 5'd0; PR2 = 5'd0;
    #2;
    push('0, '0, "reset_async_hold");
    -> async_chk;

    // Writes attempted while reset is held must be ignored.
    step(1'b0, 1'b1, 5'd4, 32'd99, 5'd4, 5'd8, 32'd0, 32'd0, "reset_hold_clk");
    step(1'b1, 1'b0, 5'd0, 32'd0,  5'd6, 5'd8, 32'd6, 32'd8, "post_reset_read");
    step(1'b1, 1'b0, 5'd0, 32'd0,  5'd4, 5'd8, 32'd4, 32'd8, "write_ignored_in_reset");

    step(1'b1, 1'b1, 5'd4, 32'd31, 5'd6, 5'd8, 32'd6, 32'd8, "write4_read6");
    step(1'b1, 1'b0, 5'd0, 32'd0,  5'd4, 5'd8, 32'd31, 32'd8, "write_readback");

    async_reset("async_reset_mid");
    step(1'b0, 1'b1, 5'd9, 32'd77, 5'd4, 5'd9, 32'd0, 32'd0, "reset_hold_mid");
    step(1'b1, 1'b0, 5'd0, 32'd0,  5'd4, 5'd9, 32'd4, 32'd9, "reg4_reinit");

    async_reset("async_reset_again");
    step(1'b1, 1'b0, 5'd0, 32'd0,  5'd10, 5'd12, 32'd10, 32'd12, "post_reset_10_12");

    step(1'b1, 1'b1, 5'd1, 32'd20, 5'd1, 5'd1, 32'd20, 32'd20, "same_cycle_wr_rd");
    step(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 32'd0, 32'd0, "r0_same_cycle");
    step(1'b1, 1'b0, 5'd0, 32'd0,  5'd0, 5'd0, 32'd0, 32'd0, "r0_protect");
    step(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, "dual_same_addr");
    step(1'b1, 1'b0, 5'd7, 32'h12345678, 5'd31, 5'd1, 32'd31, 32'd20, "write_disabled");

    // Address change mid-cycle must not reach the outputs before the falling edge.
    @(negedge clk);
    #2;
    PR1 = 5'd7; PR2 = 5'd4;
    @(posedge clk);
    #1;
    push(32'd31, 32'd20, "addr_change_hold");
    -> async_chk;
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd4, 32'hA5A5A5A5, 32'd4, "reg7_reg4_final");

    repeat (3) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
